countdown_timer: RTL and testbench

COUNTDOWN_TIMER -- requirements
Module: countdown_timer

---
 rtl/countdown_timer.sv | 167 ++++++++++++++++
 tb/tb_countdown_timer.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/countdown_timer.sv
// Countdown timer with a reload register, one-shot and periodic modes,
// pause, and a registered one-cycle terminal-count pulse.
module countdown_timer #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned MAX   = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             start,
    input  logic             pause,
    input  logic             auto_reload,
    output logic [WIDTH-1:0] out,
    output logic             busy,
    output logic             tc,
    output logic             done
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_PAUSED = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    // Largest count the timer may hold; load values above it are clamped.
    localparam logic [WIDTH-1:0] CAP  = WIDTH'(MAX - 1);
    localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);
    localparam logic [WIDTH-1:0] ZERO = '0;

    state_t           state_q;
    state_t           state_d;
    logic [WIDTH-1:0] out_q;
    logic [WIDTH-1:0] out_d;
    logic [WIDTH-1:0] reload_q;
    logic [WIDTH-1:0] reload_d;
    logic             tc_q;
    logic             tc_d;
    logic             busy_q;
    logic             busy_d;
    logic             done_q;
    logic             done_d;

    logic [WIDTH-1:0] load_clamped;
    logic             at_zero;
    logic             at_one;
    logic             tick;
    logic             reload_zero;

    // Shared decode of the current count and the tick qualifier.
    always_comb begin
        load_clamped = (load_val > CAP) ? CAP : load_val;
        at_zero      = (out_q == ZERO);
        at_one       = (out_q == ONE);
        reload_zero  = (reload_q == ZERO);
        tick         = en && !pause;
    end

    // State and datapath registers; reset clears everything at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            out_q    <= ZERO;
            reload_q <= ZERO;
            tc_q     <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            out_q    <= out_d;
            reload_q <= reload_d;
            tc_q     <= tc_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    // Next-state logic: load wins everywhere, pause beats a tick in RUN.
    always_comb begin
        state_d = state_q;
        if (load) begin
            state_d = S_IDLE;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_d = at_zero ? S_DONE : S_RUN;
                    end
                end
                S_RUN: begin
                    if (pause) begin
                        state_d = S_PAUSED;
                    end else if (en && at_one && !auto_reload) begin
                        state_d = S_DONE;
                    end
                end
                S_PAUSED: begin
                    if (!pause) begin
                        state_d = S_RUN;
                    end
                end
                S_DONE: begin
                    if (start && !reload_zero) begin
                        state_d = S_RUN;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Count, reload register, terminal-count pulse and status flags.
    always_comb begin
        out_d    = out_q;
        reload_d = reload_q;
        tc_d     = 1'b0;
        if (load) begin
            reload_d = load_clamped;
            out_d    = load_clamped;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    // Starting from zero finishes immediately with a pulse.
                    if (start && at_zero) begin
                        tc_d = 1'b1;
                    end
                end
                S_RUN: begin
                    if (tick) begin
                        if (!at_zero) begin
                            out_d = out_q - ONE;
                            tc_d  = at_one;
                        end else begin
                            // Zero is only held in RUN in periodic mode: reload.
                            out_d = reload_q;
                            tc_d  = reload_zero;
                        end
                    end
                end
                S_PAUSED: begin
                    out_d = out_q;
                end
                S_DONE: begin
                    out_d = ZERO;
                    if (start) begin
                        if (!reload_zero) begin
                            out_d = reload_q;
                        end else begin
                            tc_d = 1'b1;
                        end
                    end
                end
                default: out_d = out_q;
            endcase
        end
        busy_d = (state_d == S_RUN) || (state_d == S_PAUSED);
        done_d = (state_d == S_DONE);
    end

    assign out  = out_q;
    assign busy = busy_q;
    assign tc   = tc_q;
    assign done = done_q;

endmodule

// File: tb/tb_countdown_timer.sv
// Self-checking bench for countdown_timer: directed scenarios plus a
// randomized run, all compared against a cycle-level behavioural model.
module tb_countdown_timer;

    localparam int unsigned WIDTH = 4;
    localparam int unsigned MAX   = 10;

    localparam int M_IDLE   = 0;
    localparam int M_RUN    = 1;
    localparam int M_PAUSED = 2;
    localparam int M_DONE   = 3;

    logic             clk = 1'b0;
    logic             rst;
    logic             en;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic             start;
    logic             pause;
    logic             auto_reload;
    logic [WIDTH-1:0] out;
    logic             busy;
    logic             tc;
    logic             done;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state.
    int m_out;
    int m_reload;
    int m_phase;
    int m_tc;

    always #5 clk = ~clk;

    countdown_timer #(.WIDTH(WIDTH), .MAX(MAX)) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .load       (load),
        .load_val   (load_val),
        .start      (start),
        .pause      (pause),
        .auto_reload(auto_reload),
        .out        (out),
        .busy       (busy),
        .tc         (tc),
        .done       (done)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_out    = 0;
        m_reload = 0;
        m_phase  = M_IDLE;
        m_tc     = 0;
    endtask

    // One rising edge of the timer, written straight from the behavioural rules.
    task automatic model_edge();
        int lv;
        if (rst) begin
            model_reset();
            return;
        end
        m_tc = 0;
        if (load) begin
            lv       = (int'(load_val) > int'(MAX) - 1) ? int'(MAX) - 1 : int'(load_val);
            m_reload = lv;
            m_out    = lv;
            m_phase  = M_IDLE;
        end else if (m_phase == M_IDLE) begin
            if (start && m_out == 0) begin
                m_phase = M_DONE;
                m_tc    = 1;
            end else if (start) begin
                m_phase = M_RUN;
            end
        end else if (m_phase == M_RUN) begin
            if (pause) begin
                m_phase = M_PAUSED;
            end else if (en) begin
                if (m_out == 0) begin
                    m_out = m_reload;
                    m_tc  = (m_reload == 0) ? 1 : 0;
                end else begin
                    m_out = m_out - 1;
                    if (m_out == 0) begin
                        m_tc = 1;
                        if (!auto_reload) m_phase = M_DONE;
                    end
                end
            end
        end else if (m_phase == M_PAUSED) begin
            if (!pause) m_phase = M_RUN;
        end else begin
            if (start && m_reload != 0) begin
                m_phase = M_RUN;
                m_out   = m_reload;
            end else if (start) begin
                m_tc = 1;
            end
        end
    endtask

    task automatic compare_all(input string tag);
        chk({tag, ".out"},  32'(out),  32'(m_out));
        chk({tag, ".busy"}, 32'(busy), (m_phase == M_RUN || m_phase == M_PAUSED) ? 32'd1 : 32'd0);
        chk({tag, ".tc"},   32'(tc),   32'(m_tc));
        chk({tag, ".done"}, 32'(done), (m_phase == M_DONE) ? 32'd1 : 32'd0);
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        compare_all(tag);
    endtask

    task automatic drive(input bit l, input int lv, input bit s, input bit e,
                         input bit p, input bit ar);
        load        = l;
        load_val    = WIDTH'(lv);
        start       = s;
        en          = e;
        pause       = p;
        auto_reload = ar;
    endtask

    initial begin
        int tc_cnt;
        int busy_cnt;

        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0);
        model_reset();
        #12;
        compare_all("reset");
        @(negedge clk);
        rst = 1'b0;

        // Start with no prior load finishes at once and pulses tc.
        drive(0, 0, 1, 1, 0, 0);
        step("start_no_load");
        chk("start_no_load.done_const", 32'(done), 32'd1);
        chk("start_no_load.tc_const", 32'(tc), 32'd1);
        drive(0, 0, 0, 1, 0, 0);
        step("after_no_load");

        // One-shot from 3.
        drive(1, 3, 0, 1, 0, 0);
        step("oneshot_load");
        drive(0, 0, 1, 1, 0, 0);
        step("oneshot_start");
        drive(0, 0, 0, 1, 0, 0);
        for (int i = 0; i < 3; i++) step("oneshot_tick");
        chk("oneshot.out_const", 32'(out), 32'd0);
        chk("oneshot.tc_const", 32'(tc), 32'd1);
        chk("oneshot.done_const", 32'(done), 32'd1);
        chk("oneshot.busy_const", 32'(busy), 32'd0);
        step("oneshot_after");

        // Periodic from 2: period of three ticks.
        drive(1, 2, 0, 1, 0, 1);
        step("periodic_load");
        drive(0, 0, 1, 1, 0, 1);
        step("periodic_start");
        drive(0, 0, 0, 1, 0, 1);
        tc_cnt   = 0;
        busy_cnt = 0;
        for (int i = 0; i < 9; i++) begin
            step("periodic_tick");
            tc_cnt   += int'(tc);
            busy_cnt += int'(busy);
        end
        chk("periodic.tc_count", 32'(tc_cnt), 32'd3);
        chk("periodic.busy_count", 32'(busy_cnt), 32'd9);

        // Load above the range clamps to MAX-1.
        drive(1, 15, 0, 1, 0, 0);
        step("clamp");
        chk("clamp.out_const", 32'(out), 32'd9);

        // Pause at 3 while counting from 5.
        drive(1, 5, 0, 1, 0, 0);
        step("pause_load");
        drive(0, 0, 1, 1, 0, 0);
        step("pause_start");
        drive(0, 0, 0, 1, 0, 0);
        step("pause_tick");
        step("pause_tick");
        drive(0, 0, 0, 1, 1, 0);
        for (int i = 0; i < 4; i++) begin
            step("paused");
            chk("paused.out_const", 32'(out), 32'd3);
            chk("paused.busy_const", 32'(busy), 32'd1);
        end
        drive(0, 0, 0, 1, 0, 0);
        step("resume");
        for (int i = 0; i < 3; i++) step("resume_tick");
        chk("resume.out_const", 32'(out), 32'd0);
        chk("resume.done_const", 32'(done), 32'd1);

        // Load and start together: start ignored.
        drive(1, 4, 1, 1, 0, 0);
        step("load_start");
        chk("load_start.out_const", 32'(out), 32'd4);
        chk("load_start.busy_const", 32'(busy), 32'd0);

        // Asynchronous reset mid-count at 6.
        drive(1, 8, 0, 1, 0, 0);
        step("arst_load");
        drive(0, 0, 1, 1, 0, 0);
        step("arst_start");
        drive(0, 0, 0, 1, 0, 0);
        step("arst_tick");
        step("arst_tick");
        chk("arst.pre_out", 32'(out), 32'd6);
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        compare_all("arst_immediate");
        chk("arst.out_const", 32'(out), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Randomized traffic with occasional resets and mode changes.
        for (int i = 0; i < 3000; i++) begin
            rst         = ($urandom_range(0, 299) == 0);
            load        = ($urandom_range(0, 19) == 0);
            load_val    = WIDTH'($urandom_range(0, 15));
            start       = ($urandom_range(0, 7) == 0);
            en          = ($urandom_range(0, 3) != 0);
            pause       = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 31) == 0) auto_reload = ~auto_reload;
            step("random");
        end
        rst = 1'b0;

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
